round_sequencer: RTL and testbench
==================================

Name: round_sequencer

Overview:
- Control-side companion to the 2-bit round counter used in the cipher datapath.
- Generates the round index sequence for one block operation: ascending (0..ROUNDS-1) for encryption, descending (ROUNDS-1..0) for decryption.
- Handshakes each round with the datapath through round_valid and round_ack, then emits a single-cycle done pulse.

Parameters:
- ROUNDS, 4: number of rounds per block. Legal range is 1..2^IDX_W.
- IDX_W, 2: width of round_idx.

Ports:
- clk  input  1  system clock; all logic is sampled on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- start  input  1  begin an operation. Sampled only in IDLE.
- decrypt  input  1  direction select: 0 = ascending, 1 = descending. Sampled together with start.
- abort  input  1  cancel the current operation. Effective in RUN and DONE.
- round_ack  input  1  datapath has completed the current round. Meaningful only while round_valid=1.
- round_idx  output  IDX_W  current round index.
- round_valid  output  1  round_idx is valid and the datapath may process that round.
- first_round  output  1  high when round_valid=1 and this is the first round of the sequence.
- last_round  output  1  high when round_valid=1 and this is the final round of the sequence.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle completion pulse.
- mode  output  1  latched copy of decrypt for the current operation.

Behaviour:
- Reset: when rstn=0 at a clock edge, the block goes to IDLE and clears round_idx, round_valid, first_round, last_round, busy, done and mode to 0. Reset has priority over every other input, including mid-operation.
- All outputs are registered. No combinational path runs from any input to any output.
- Terminal index is defined as ROUNDS-1 when mode=0 and 0 when mode=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs: busy=0, round_valid=0.
  - round_idx holds the final index of the previous operation (0 after reset).
  - On start=1: latch mode<=decrypt; set round_idx<=(decrypt ? ROUNDS-1 : 0); set round_valid=1 and first_round=1; go to RUN.
  - This gives 1 cycle of latency from start to the first valid round.
- RUN, general:
  - Outputs: busy=1, round_valid=1.
  - first_round is high only until the first round_ack.
  - last_round is high while round_idx equals the terminal index.
- RUN, on round_ack=1 when not at the terminal index:
  - round_idx<=round_idx+1 if mode=0, or round_idx-1 if mode=1.
  - Stay in RUN. The next index is visible on the following cycle, so the sequencer supports back-to-back acks at one round per cycle.
- RUN, on round_ack=1 at the terminal index:
  - Go to DONE with round_valid<=0 and done<=1.
  - round_idx holds the terminal value.
- RUN, with round_ack=0: hold all state. There is no timeout.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then go to IDLE with done<=0.
- Ignored inputs:
  - start in RUN or DONE is ignored. It is not queued.
  - round_ack outside RUN is ignored.
- abort:
  - abort=1 in RUN or DONE: go to IDLE with round_valid=0, done=0 and round_idx<=0. No done pulse is produced.
  - abort has priority over round_ack in the same cycle.
  - abort in IDLE has no effect. If abort and start are both high in IDLE, start is accepted.
- ROUNDS=1: first_round and last_round are both high during the single round. One ack leads to DONE.
- Arithmetic:
  - The index never steps past the terminal value, so no wrap-around occurs.
  - Index arithmetic is IDX_W bits wide, unsigned.
- Implementation must include an assertion or elaboration check that ROUNDS<=2^IDX_W and ROUNDS>=1.

Test Plan:
- Reset, encrypt, continuous ack: rstn=0 for 2 cycles, then start=1 and decrypt=0 for 1 cycle, then round_ack=1 held -> round_idx reads 0,1,2,3 on consecutive cycles. first_round is high at idx 0 and last_round is high at idx 3. done pulses for 1 cycle on the cycle after the ack at idx 3. busy falls the cycle after done.
- Decrypt, stalled acks: start with decrypt=1, then round_ack asserted every third cycle -> round_idx reads 3,2,1,0. Each value holds until its ack. mode=1 throughout. done pulses exactly once.
- Abort mid-run: encrypt start, ack at idx 0 and idx 1, then abort=1 together with round_ack=1 at idx 2 -> IDLE next cycle with round_idx=0, round_valid=0 and no done pulse. A following start begins cleanly at idx 0.
- start while busy: start=1 pulses during RUN and during DONE -> no effect. The sequence and mode are unchanged, and only one done pulse occurs.
- Reset mid-operation: rstn=0 while at idx 2 of a decrypt -> on the next edge all outputs are 0 and the state is IDLE. round_ack held high during reset produces no index change.
- ROUNDS=1, IDX_W=1 instance: start, then a single ack -> first_round=1 and last_round=1 with idx 0, done one cycle after the ack, for both values of decrypt.

Source files
------------

// File: rtl/round_sequencer_if.sv
// round_sequencer_if: control/datapath handshake bundle between the round sequencer and its users.
interface round_sequencer_if #(parameter int IDX_W = 2);
  logic start, decrypt, abort, round_ack;
  logic [IDX_W-1:0] round_idx;
  logic round_valid, first_round, last_round, busy, done, mode;
  modport master (
    output start, decrypt, abort, round_ack,
    input  round_idx, round_valid, first_round, last_round, busy, done, mode
  );
  modport slave (
    input  start, decrypt, abort, round_ack,
    output round_idx, round_valid, first_round, last_round, busy, done, mode
  );
endinterface

// File: rtl/round_sequencer.sv
// round_sequencer: walks the round index up (encrypt) or down (decrypt), one round per ack, then pulses done.
module round_sequencer #(
  parameter int ROUNDS = 4,
  parameter int IDX_W  = 2
) (
  input logic clk,
  input logic rstn,
  round_sequencer_if.slave bus
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);
  if (ROUNDS < 1 || ROUNDS > 2 ** IDX_W) begin : g_bad_rounds
    $error("round_sequencer: ROUNDS must lie within 1..2**IDX_W");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic busy_q, busy_d, done_q, done_d, mode_q, mode_d;
  logic at_term;
  assign at_term = idx_q == (mode_q ? '0 : LAST);
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    first_d = first_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          mode_d  = bus.decrypt;
          idx_d   = bus.decrypt ? LAST : '0;
          valid_d = 1'b1;
          first_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = '0;
          valid_d = 1'b0;
          first_d = 1'b0;
        end else if (bus.round_ack) begin
          first_d = 1'b0;
          if (at_term) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = mode_q ? idx_q - 1'b1 : idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = bus.abort ? '0 : idx_q;
      end
    endcase
    // flags are derived from next state so every output stays a plain flop
    busy_d = state_d != IDLE;
    last_d = valid_d && idx_d == (mode_d ? '0 : LAST);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end
  assign bus.round_idx   = idx_q;
  assign bus.round_valid = valid_q;
  assign bus.first_round = first_q;
  assign bus.last_round  = last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mode        = mode_q;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed vector table for a 4-round instance plus hand sequences for a 1-round instance.
module tb_round_sequencer;
  // in = {rstn, start, decrypt, abort, round_ack}; fl = {valid, first, last, busy, done, mode}
  typedef struct packed {
    logic [4:0] in;
    logic [1:0] idx;
    logic [5:0] fl;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int passed = 0;
  int total = 0;
  vec_t vq[$];
  round_sequencer_if #(.IDX_W(2)) b4();
  round_sequencer_if #(.IDX_W(1)) b1();
  round_sequencer #(.ROUNDS(4), .IDX_W(2)) dut4 (.clk(clk), .rstn(rstn), .bus(b4.slave));
  round_sequencer #(.ROUNDS(1), .IDX_W(1)) dut1 (.clk(clk), .rstn(rstn), .bus(b1.slave));
  always #5 clk = ~clk;
  function automatic logic [7:0] obs4();
    return {b4.round_idx, b4.round_valid, b4.first_round, b4.last_round, b4.busy, b4.done, b4.mode};
  endfunction
  function automatic logic [7:0] obs1();
    return {1'b0, b1.round_idx, b1.round_valid, b1.first_round, b1.last_round, b1.busy, b1.done, b1.mode};
  endfunction
  task automatic add(input logic [4:0] in, input logic [1:0] idx, input logic [5:0] fl);
    vq.push_back('{in: in, idx: idx, fl: fl});
  endtask
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got idx/flags %b, expected %b", name, act, exp);
  endtask
  initial begin
    {b4.start, b4.decrypt, b4.abort, b4.round_ack} = '0;
    {b1.start, b1.decrypt, b1.abort, b1.round_ack} = '0;
    // reset, encrypt with ack held
    add(5'b0_0_0_0_0, 2'd0, 6'b000000);
    add(5'b0_0_0_0_0, 2'd0, 6'b000000);
    add(5'b1_1_0_0_0, 2'd0, 6'b110100);
    add(5'b1_0_0_0_1, 2'd1, 6'b100100);
    add(5'b1_0_0_0_1, 2'd2, 6'b100100);
    add(5'b1_0_0_0_1, 2'd3, 6'b101100);
    add(5'b1_0_0_0_1, 2'd3, 6'b000110);
    add(5'b1_0_0_0_1, 2'd3, 6'b000000);
    // decrypt, ack every third cycle
    add(5'b1_1_1_0_0, 2'd3, 6'b110101);
    add(5'b1_0_0_0_0, 2'd3, 6'b110101);
    add(5'b1_0_0_0_0, 2'd3, 6'b110101);
    add(5'b1_0_0_0_1, 2'd2, 6'b100101);
    add(5'b1_0_0_0_0, 2'd2, 6'b100101);
    add(5'b1_0_0_0_0, 2'd2, 6'b100101);
    add(5'b1_0_0_0_1, 2'd1, 6'b100101);
    add(5'b1_0_0_0_0, 2'd1, 6'b100101);
    add(5'b1_0_0_0_0, 2'd1, 6'b100101);
    add(5'b1_0_0_0_1, 2'd0, 6'b101101);
    add(5'b1_0_0_0_0, 2'd0, 6'b101101);
    add(5'b1_0_0_0_0, 2'd0, 6'b101101);
    add(5'b1_0_0_0_1, 2'd0, 6'b000111);
    add(5'b1_0_0_0_0, 2'd0, 6'b000001);
    // abort beats ack at idx 2, then a clean restart
    add(5'b1_1_0_0_0, 2'd0, 6'b110100);
    add(5'b1_0_0_0_1, 2'd1, 6'b100100);
    add(5'b1_0_0_0_1, 2'd2, 6'b100100);
    add(5'b1_0_0_1_1, 2'd0, 6'b000000);
    add(5'b1_0_0_0_0, 2'd0, 6'b000000);
    add(5'b1_1_0_0_0, 2'd0, 6'b110100);
    // start while busy is ignored in RUN and DONE
    add(5'b1_1_1_0_0, 2'd0, 6'b110100);
    add(5'b1_1_1_0_1, 2'd1, 6'b100100);
    add(5'b1_0_0_0_1, 2'd2, 6'b100100);
    add(5'b1_1_0_0_1, 2'd3, 6'b101100);
    add(5'b1_1_1_0_1, 2'd3, 6'b000110);
    add(5'b1_1_1_0_0, 2'd3, 6'b000000);
    add(5'b1_0_0_0_0, 2'd3, 6'b000000);
    // reset mid decrypt with ack held
    add(5'b1_1_1_0_0, 2'd3, 6'b110101);
    add(5'b1_0_0_0_1, 2'd2, 6'b100101);
    add(5'b0_0_0_0_1, 2'd0, 6'b000000);
    add(5'b0_1_0_0_1, 2'd0, 6'b000000);
    add(5'b1_0_0_0_1, 2'd0, 6'b000000);
    // start+abort in IDLE accepted; abort in DONE zeroes idx
    add(5'b1_1_0_1_0, 2'd0, 6'b110100);
    add(5'b1_0_0_0_1, 2'd1, 6'b100100);
    add(5'b1_0_0_0_1, 2'd2, 6'b100100);
    add(5'b1_0_0_0_1, 2'd3, 6'b101100);
    add(5'b1_0_0_0_1, 2'd3, 6'b000110);
    add(5'b1_0_0_1_0, 2'd0, 6'b000000);
    foreach (vq[i]) begin
      {rstn, b4.start, b4.decrypt, b4.abort, b4.round_ack} = vq[i].in;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs4(), {vq[i].idx, vq[i].fl});
    end
    {rstn, b4.start, b4.decrypt, b4.abort, b4.round_ack} = 5'b1_0_0_0_0;
    // single-round instance, both directions
    for (int d = 0; d < 2; d++) begin
      b1.start = 1'b1;
      b1.decrypt = d[0];
      @(posedge clk);
      #1;
      b1.start = 1'b0;
      check($sformatf("r1_start_d%0d", d), obs1(), {2'b00, 5'b11110, d[0]});
      b1.round_ack = 1'b1;
      @(posedge clk);
      #1;
      b1.round_ack = 1'b0;
      check($sformatf("r1_done_d%0d", d), obs1(), {2'b00, 5'b00011, d[0]});
      @(posedge clk);
      #1;
      check($sformatf("r1_idle_d%0d", d), obs1(), {2'b00, 5'b00000, d[0]});
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
